jt51_host: RTL



---
 rtl/jt51_host_pkg.sv | 27 ++
 rtl/jt51_host_if.sv | 28 ++
 rtl/jt51_host_fifo.sv | 65 ++++++
 rtl/jt51_host.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/jt51_host_pkg.sv
// jt51_host_pkg: shared types and constants for the JT51 host bus initiator.
//   state_e  - FSM states of jt51_host
//   pair_t   - one queued register write {addr, data}
//   BUSY_BIT - index of the busy flag in the jt51 status byte
//   CNT_W    - width of the shared state down-counter
package jt51_host_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAwr,
        StAgap,
        StDwr,
        StSettle,
        StBwait
    } state_e;

    localparam int unsigned BUSY_BIT = 7;

    // Wide enough for the largest load value (TIMEOUT - 1).
    localparam int unsigned CNT_W = 16;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } pair_t;

endpackage

// File: rtl/jt51_host_if.sv
// jt51_host_if: client request channel into jt51_host.
//   req_valid - client offers a pair
//   req_ready - host FIFO not full; pair taken on req_valid && req_ready
//   req_addr  - YM2151 register address
//   req_data  - register data
// Modports: master (client side), slave (jt51_host side).
interface jt51_host_if;

    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_addr;
    logic [7:0] req_data;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/jt51_host_fifo.sv
// jt51_host_fifo: synchronous FIFO, depth 2**AW, registered write.
//   clk, rst_n - clock, asynchronous active-low reset (clears pointers/count)
//   push/wdata - write request; ignored when full
//   pop/rdata  - read request; rdata shows the head entry, ignored when empty
//   full/empty - status flags
//   level      - entries held, 0..2**AW
module jt51_host_fifo #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt_q == (AW + 1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign level   = cnt_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/jt51_host.sv
// jt51_host: bus initiator for the JT51 CPU port. Queued {addr, data} pairs are
// issued as an address write (a0=0) then a data write (a0=1); the block then
// waits for status[7] (busy) to clear before the next pair.
//   clk, rst_n     - clock, asynchronous active-low reset
//   req            - jt51_host_if.slave request channel (valid/ready/addr/data)
//   level          - pairs queued, excluding the one in flight
//   idle           - FIFO empty and FSM idle
//   err, err_clr   - sticky busy-timeout flag and its clear
//   cs_n, wr_n, a0 - jt51 bus strobes / register select
//   dout           - byte driven to jt51 din
//   status         - jt51 dout; only the busy bit is used
// Optional: define JT51_HOST_TIMEOUT_EN to bound the busy wait to TIMEOUT cycles
// and flag err; otherwise the wait is unbounded and err is tied low.
module jt51_host
    import jt51_host_pkg::*;
#(
    parameter int unsigned FIFO_AW = 4,
    parameter int unsigned WR_LEN  = 4,
    parameter int unsigned GAP_LEN = 2,
    parameter int unsigned SETTLE  = 8,
    parameter int unsigned TIMEOUT = 2047
) (
    input  logic             clk,
    input  logic             rst_n,
    jt51_host_if.slave       req,
    output logic [FIFO_AW:0] level,
    output logic             idle,
    output logic             err,
    input  logic             err_clr,
    output logic             cs_n,
    output logic             wr_n,
    output logic             a0,
    output logic [7:0]       dout,
    input  logic [7:0]       status
);

    localparam logic [CNT_W-1:0] WR_LOAD     = CNT_W'(WR_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_LEN - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] TO_LOAD     = CNT_W'(TIMEOUT - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             strobe_n_q;
    logic             a0_q;
    logic [7:0]       dout_q;
    logic [7:0]       data_q;

    pair_t head;
    logic  empty;
    logic  full;
    logic  pop;

    assign req.req_ready = !full;
    assign pop           = (state_q == StIdle) && !empty;
    assign idle          = (state_q == StIdle) && empty;

    // One register feeds both strobes so they can never skew apart.
    assign cs_n = strobe_n_q;
    assign wr_n = strobe_n_q;
    assign a0   = a0_q;
    assign dout = dout_q;

    jt51_host_fifo #(
        .AW (FIFO_AW),
        .DW (16)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req.req_valid && req.req_ready),
        .wdata ({req.req_addr, req.req_data}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // The shared counter is loaded with (cycles - 1) on each state entry; the
    // state exits on the cycle it reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            strobe_n_q <= 1'b1;
            a0_q       <= 1'b0;
            dout_q     <= '0;
            data_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!empty) begin
                        dout_q     <= head.addr;
                        data_q     <= head.data;
                        a0_q       <= 1'b0;
                        strobe_n_q <= 1'b0;
                        cnt_q      <= WR_LOAD;
                        state_q    <= StAwr;
                    end
                end
                StAwr: begin
                    if (cnt_q == '0) begin
                        strobe_n_q <= 1'b1;
                        cnt_q      <= GAP_LOAD;
                        state_q    <= StAgap;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StAgap: begin
                    if (cnt_q == '0) begin
                        a0_q       <= 1'b1;
                        dout_q     <= data_q;
                        strobe_n_q <= 1'b0;
                        cnt_q      <= WR_LOAD;
                        state_q    <= StDwr;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StDwr: begin
                    if (cnt_q == '0) begin
                        strobe_n_q <= 1'b1;
                        cnt_q      <= SETTLE_LOAD;
                        state_q    <= StSettle;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StSettle: begin
                    // Busy is not yet valid here: the chip needs a cen_p1
                    // sample plus a register stage to raise it.
                    if (cnt_q == '0) begin
                        cnt_q   <= TO_LOAD;
                        state_q <= StBwait;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StBwait: begin
                    if (!status[BUSY_BIT]) begin
                        state_q <= StIdle;
`ifdef JT51_HOST_TIMEOUT_EN
                    end else if (cnt_q == '0) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
`endif
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef JT51_HOST_TIMEOUT_EN
    logic err_q;
    logic timeout_hit;

    assign timeout_hit = (state_q == StBwait) && status[BUSY_BIT] && (cnt_q == '0);
    assign err         = err_q;

    // A timeout on the same edge as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end
`else
    logic unused_err_clr;

    assign err            = 1'b0;
    assign unused_err_clr = err_clr;
`endif

    // Only the busy bit of status is meaningful.
    logic unused_status;
    assign unused_status = ^(status & ~(8'h01 << BUSY_BIT));

endmodule
